conversor_bcd_seq: RTL
======================

CONVERSOR_BCD_SEQ -- requirements
Module: conversor_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 32: binary input width in bits, legal range 4..64.
REQ-002 Parameter DIGITS, default 10: number of BCD output digits, legal range 1..20.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a conversion; sampled on the rising edge.
REQ-006 value  input  WIDTH  binary operand; captured only in the cycle start is accepted.
REQ-007 signed_in  input  1  1 = value is two's complement; 0 = value is unsigned; captured together with value.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse; bcd/neg/overflow are valid from this cycle on.
REQ-010 bcd  output  4*DIGITS  result digits, little-endian by digit: [3:0] = units, [7:4] = tens, and so on.
REQ-011 neg  output  1  result sign; 1 = negative.
REQ-012 overflow  output  1  magnitude needs more than DIGITS decimal digits.

Function
REQ-013 FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 Transitions:
- IDLE -> SHIFT on start.
- SHIFT -> DONE after exactly WIDTH iterations.
- DONE -> SHIFT if start is high in the DONE cycle; otherwise DONE -> IDLE.
REQ-015 Start acceptance:
- start is accepted only in IDLE or DONE.
- start while busy=1 is ignored and does not disturb the running conversion.
REQ-016 On acceptance, the block SHALL compute magnitude and sign:
- neg_int = signed_in & value[WIDTH-1].
- magnitude = two's-complement negation of value when neg_int = 1; otherwise value.
- The magnitude is held in an unsigned WIDTH-bit register, so -2^(WIDTH-1) converts exactly.
REQ-017 Each SHIFT cycle SHALL perform one double-dabble iteration:
- every digit of the working register that is >4 has 3 added;
- the digit chain is then shifted left by 1, with the magnitude MSB entering the units digit;
- the magnitude register is then shifted left by 1.
REQ-018 Overflow detection:
- A 1 shifted out of the top digit's bit 3 on any iteration SHALL set an internal sticky overflow flag for that conversion.
- The flag is cleared on acceptance of start.
REQ-019 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-020 Latency: start accepted at edge N -> done = 1 during the cycle after edge N+WIDTH; throughput is one result per WIDTH+1 cycles.
REQ-021 Output registers:
- bcd, neg and overflow are loaded on the edge that enters DONE.
- They then hold their values until the next DONE entry.
- They do not change during SHIFT.
REQ-022 On overflow, bcd SHALL hold the magnitude modulo 10^DIGITS; every digit is always in 0..9.
REQ-023 A magnitude of 0 SHALL give neg = 0, so negative zero is never reported.

Reset
REQ-024 While rst_n = 0, regardless of clk:
- state = IDLE; busy = 0, done = 0, bcd = 0, neg = 0, overflow = 0;
- working and magnitude registers cleared.
REQ-025 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification (WIDTH=32, DIGITS=10 unless noted)
REQ-026 Unsigned round trip:
- value = 12345678, signed_in = 0, start pulse -> done exactly 33 cycles after the start edge;
- bcd = 0x0000_1234_5678 (10 digits), neg = 0, overflow = 0.
REQ-027 Signed edges:
- 0xFFFF_FFFF signed -> neg = 1, bcd = 1.
- 0x8000_0000 signed -> neg = 1, bcd digits = 2147483648.
- 0xFFFF_FFFF unsigned -> neg = 0, bcd digits = 4294967295.
REQ-028 Overflow (DIGITS = 4): value = 12345 unsigned -> overflow = 1, bcd = 0x2345; a following value = 9999 -> overflow = 0, bcd = 0x9999.
REQ-029 Handshake: start held high continuously with changing value:
- start is accepted only at IDLE/DONE;
- back-to-back results arrive every 33 cycles;
- each result matches the value present at its acceptance edge.
REQ-030 Reset: rst_n pulsed low 10 cycles after start -> outputs are 0 immediately (asynchronously), no done pulse; a new start of value = 0 -> bcd = 0, neg = 0 after 33 cycles.

Source files
------------

// File: rtl/conversor_bcd_seq.sv
// Sequential binary (unsigned or two's complement) to BCD converter, one double-dabble step per cycle.
// Latency WIDTH+1 cycles from the start edge to done; start is ignored while busy.
module conversor_bcd_seq #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  signed_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] mag;
  logic [BW-1:0]   work;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   work_nxt;
  logic            neg_int;
  logic            ovf_int;
  logic            ovf_nxt;
  logic            accept;
  logic            last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);

  // Add-3 correction, then shift; a bit leaving the top digit is a carry past 10^DIGITS.
  always_comb begin
    adj = work;
    for (int i = 0; i < DIGITS; i++) begin
      if (work[4*i +: 4] > 4'd4) begin
        adj[4*i +: 4] = work[4*i +: 4] + 4'd3;
      end
    end
    work_nxt = {adj[BW-2:0], mag[WIDTH-1]};
    ovf_nxt  = ovf_int | adj[BW-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      mag      <= '0;
      work     <= '0;
      neg_int  <= 1'b0;
      ovf_int  <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // A negative operand has its MSB set, so its magnitude is never zero.
      neg_int <= signed_in & value[WIDTH-1];
      mag     <= (signed_in & value[WIDTH-1]) ? -value : value;
      work    <= '0;
      ovf_int <= 1'b0;
      cnt     <= '0;
    end else if (state == SHIFT) begin
      work    <= work_nxt;
      mag     <= {mag[WIDTH-2:0], 1'b0};
      ovf_int <= ovf_nxt;
      cnt     <= cnt + CW'(1);
      if (last) begin
        bcd      <= work_nxt;
        neg      <= neg_int;
        overflow <= ovf_nxt;
      end
    end
  end

endmodule
